// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, active window and line/frame strobes from active-low VGA syncs, with lock tracking.
// Strobes, coordinates and status are registered; no backpressure, one decision per pixel clock.
module vga_sync_decoder #(
   parameter int H_ACT_START = 144,
   parameter int H_ACT       = 640,
   parameter int V_ACT_START = 35,
   parameter int V_ACT       = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iH_SYNC,
   input  logic        iV_SYNC,
   output logic [9:0]  oX,
   output logic [9:0]  oY,
   output logic        oActive,
   output logic        oLineStart,
   output logic        oFrameStart,
   output logic [10:0] oH_Total,
   output logic [10:0] oV_Total,
   output logic        oLocked,
   output logic        oErr
);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   localparam logic [10:0] CNT_MAX = 11'd2047;
   localparam logic [10:0] H_LO    = 11'(H_ACT_START);
   localparam logic [10:0] H_HI    = 11'(H_ACT_START + H_ACT);
   localparam logic [10:0] V_LO    = 11'(V_ACT_START);
   localparam logic [10:0] V_HI    = 11'(V_ACT_START + V_ACT);
   localparam logic [15:0] LOCK_N  = 16'(LOCK_FRAMES);

   state_t      state;
   logic        s_h, s_v, p_h, p_v;
   logic        fall_h, fall_v, boundary, timeout;
   logic [10:0] h_cnt, v_cnt;
   logic        vs_pend;
   logic [11:0] line_len, frame_v_now, frame_h;
   logic        have_h, line_bad, frame_ok, seen;
   logic [10:0] ref_h, ref_v;
   logic [15:0] match;
   logic        h_win, v_win, act_r;
   logic [9:0]  x_r, y_r;

   assign fall_h      = p_h & ~s_h;
   assign fall_v      = p_v & ~s_v;
   assign boundary    = fall_h & (vs_pend | fall_v);
   assign timeout     = (h_cnt == CNT_MAX);
   assign line_len    = {1'b0, h_cnt} + 12'd1;
   assign frame_v_now = {1'b0, v_cnt} + 12'd1;
   // 12-bit compares keep an over-range total from ever matching an 11-bit reference
   assign frame_ok    = have_h & ~line_bad & (frame_h == {1'b0, ref_h}) & (frame_v_now == {1'b0, ref_v});
   assign h_win       = (h_cnt >= H_LO) && (h_cnt < H_HI);
   assign v_win       = (v_cnt >= V_LO) && (v_cnt < V_HI);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         s_h <= 1'b0; s_v <= 1'b0; p_h <= 1'b0; p_v <= 1'b0;
         h_cnt <= '0; v_cnt <= '0; vs_pend <= 1'b0;
         frame_h <= '0; have_h <= 1'b0; line_bad <= 1'b0;
         oLineStart <= 1'b0; oFrameStart <= 1'b0;
         act_r <= 1'b0; x_r <= '0; y_r <= '0;
      end else begin
         s_h <= iH_SYNC; s_v <= iV_SYNC;
         p_h <= s_h;     p_v <= s_v;
         if (fall_h)
            h_cnt <= '0;
         else if (h_cnt != CNT_MAX)
            h_cnt <= h_cnt + 11'd1;
         if (boundary) begin
            v_cnt   <= '0;
            vs_pend <= 1'b0;
         end else begin
            if (fall_v)
               vs_pend <= 1'b1;
            if (fall_h && v_cnt != CNT_MAX)
               v_cnt <= v_cnt + 11'd1;
         end
         // the line ending on a boundary belongs to the old frame and is not scored
         if (boundary) begin
            frame_h  <= '0;
            have_h   <= 1'b0;
            line_bad <= 1'b0;
         end else if (fall_h) begin
            if (!have_h) begin
               frame_h <= line_len;
               have_h  <= 1'b1;
            end else if (line_len != frame_h) begin
               line_bad <= 1'b1;
            end
         end
         oLineStart  <= fall_h;
         oFrameStart <= boundary;
         act_r <= h_win & v_win;
         x_r   <= (h_win && v_win) ? 10'(h_cnt - H_LO) : '0;
         y_r   <= (h_win && v_win) ? 10'(v_cnt - V_LO) : '0;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state   <= SEARCH;
         seen    <= 1'b0;
         ref_h   <= '0;
         ref_v   <= '0;
         match   <= '0;
         oLocked <= 1'b0;
         oErr    <= 1'b0;
      end else begin
         oErr <= 1'b0;
         if (timeout) begin
            state   <= SEARCH;
            seen    <= 1'b0;
            oLocked <= 1'b0;
            oErr    <= (state == LOCKED);
         end else begin
            case (state)
               SEARCH: begin
                  if (boundary) begin
                     if (seen) begin
                        ref_h <= frame_h[10:0];
                        ref_v <= frame_v_now[10:0];
                        match <= '0;
                        state <= TRACK;
                     end else begin
                        seen <= 1'b1;
                     end
                  end
               end
               TRACK: begin
                  if (boundary) begin
                     if (frame_ok) begin
                        match <= match + 16'd1;
                        if (match + 16'd1 == LOCK_N) begin
                           state   <= LOCKED;
                           oLocked <= 1'b1;
                        end
                     end else begin
                        ref_h <= frame_h[10:0];
                        ref_v <= frame_v_now[10:0];
                        match <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if ((fall_h && line_len != {1'b0, ref_h}) ||
                      (boundary && frame_v_now != {1'b0, ref_v})) begin
                     state   <= SEARCH;
                     seen    <= 1'b0;
                     oLocked <= 1'b0;
                     oErr    <= 1'b1;
                  end
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end

   assign oActive  = act_r & oLocked;
   assign oX       = oLocked ? x_r : '0;
   assign oY       = oLocked ? y_r : '0;
   assign oH_Total = oLocked ? ref_h : '0;
   assign oV_Total = oLocked ? ref_v : '0;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled 40x14 raster: frame-level reference model checked every cycle,
// plus literal expectations for lock timing, totals, active counts and error pulses.
module tb_vga_sync_decoder;

   localparam int HS = 12, HA = 20, VS = 3, VA = 8, LF = 2;
   localparam int HT = 40, VT = 14, HSW = 4;

   logic       clk = 1'b0, rst = 1'b1, hs = 1'b1, vs = 1'b1;
   logic [9:0] x, y;
   logic       act, ls, fs, locked, err;
   logic [10:0] ht, vt;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_ACT_START(HS), .H_ACT(HA), .V_ACT_START(VS), .V_ACT(VA), .LOCK_FRAMES(LF)
   ) dut (
      .iCLK(clk), .iRST(rst), .iH_SYNC(hs), .iV_SYNC(vs),
      .oX(x), .oY(y), .oActive(act), .oLineStart(ls), .oFrameStart(fs),
      .oH_Total(ht), .oV_Total(vt), .oLocked(locked), .oErr(err)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
      end
   endtask

   // Model state: sync history, position in line/frame, current frame record, lock progress.
   bit m_ph, m_sh, m_pv, m_sv, m_vp, m_lock, m_have, m_uni;
   int m_pos, m_vc, m_nb, m_run, m_refh, m_refv, m_curh;

   // Observed-event tallies used by the literal checks.
   int fs_cnt = 0, err_cnt = 0, lock_fs = -1, lock_with_fs = 0, err_fs = -1, fs_no_ls = 0;
   int act_cnt = 0, fx = -1, fy = -1, lx = -1, ly = -1;
   int prev_act = -1, pfx = -1, pfy = -1, plx = -1, ply = -1;
   bit prev_locked = 1'b0;

   initial begin : model_and_compare
      bit fh, fv, bnd, win, e_err;
      int len, wx, wy;
      forever begin
         @(posedge clk);
         #1;
         e_err = 1'b0; fh = 1'b0; bnd = 1'b0; win = 1'b0; wx = 0; wy = 0;
         if (rst) begin
            m_ph = 0; m_sh = 0; m_pv = 0; m_sv = 0; m_vp = 0; m_lock = 0; m_have = 0; m_uni = 0;
            m_pos = 0; m_vc = 0; m_nb = 0; m_run = 0; m_refh = 0; m_refv = 0; m_curh = 0;
         end else begin
            fh  = m_ph && !m_sh;
            fv  = m_pv && !m_sv;
            bnd = fh && (m_vp || fv);
            win = (m_pos >= HS) && (m_pos < HS + HA) && (m_vc >= VS) && (m_vc < VS + VA);
            wx  = m_pos - HS;
            wy  = m_vc - VS;
            len = m_pos + 1;
            if (m_pos == 2047) begin
               e_err = m_lock; m_lock = 0; m_nb = 0;
            end else if (m_lock) begin
               if ((fh && len != m_refh) || (bnd && m_vc + 1 != m_refv)) begin
                  e_err = 1; m_lock = 0; m_nb = 0;
               end
            end else if (bnd) begin
               if (m_nb == 0)
                  m_nb = 1;
               else if (m_nb == 1 || !(m_have && m_uni && m_curh == m_refh && m_vc + 1 == m_refv)) begin
                  m_refh = m_curh % 2048; m_refv = (m_vc + 1) % 2048; m_run = 0; m_nb = 2;
               end else begin
                  m_run++;
                  if (m_run == LF) m_lock = 1;
               end
            end
            if (bnd) begin
               m_curh = 0; m_have = 0; m_uni = 1;
            end else if (fh) begin
               if (!m_have) begin m_curh = len; m_have = 1; end
               else if (len != m_curh) m_uni = 0;
            end
            if (bnd) begin
               m_vc = 0; m_vp = 0;
            end else begin
               if (fv) m_vp = 1;
               if (fh && m_vc < 2047) m_vc++;
            end
            m_pos = fh ? 0 : ((m_pos < 2047) ? m_pos + 1 : 2047);
            m_ph = m_sh; m_sh = hs; m_pv = m_sv; m_sv = vs;
         end
         chk("oLineStart",  int'(ls),     int'(fh));
         chk("oFrameStart", int'(fs),     int'(bnd));
         chk("oLocked",     int'(locked), int'(m_lock));
         chk("oErr",        int'(err),    int'(e_err));
         chk("oActive",     int'(act),    int'(win && m_lock));
         chk("oX",          int'(x),      (win && m_lock) ? wx : 0);
         chk("oY",          int'(y),      (win && m_lock) ? wy : 0);
         chk("oH_Total",    int'(ht),     m_lock ? m_refh : 0);
         chk("oV_Total",    int'(vt),     m_lock ? m_refv : 0);

         if (fs) begin
            fs_cnt++;
            if (!ls) fs_no_ls++;
            prev_act = act_cnt; pfx = fx; pfy = fy; plx = lx; ply = ly;
            act_cnt = 0; fx = -1; fy = -1; lx = -1; ly = -1;
         end
         if (act) begin
            if (act_cnt == 0) begin fx = int'(x); fy = int'(y); end
            act_cnt++;
            lx = int'(x); ly = int'(y);
         end
         if (err) begin err_cnt++; err_fs = fs_cnt; end
         if (locked && !prev_locked) begin lock_fs = fs_cnt; lock_with_fs = int'(fs); end
         prev_locked = locked;
      end
   end

   task automatic drive(input logic h, input logic v);
      @(negedge clk);
      hs = h;
      vs = v;
   endtask

   task automatic line(input int len, input bit vlow);
      for (int i = 0; i < len; i++) drive(i >= HSW, !vlow);
   endtask

   task automatic frame(input int stretch);
      for (int l = 0; l < VT; l++) line((l == stretch) ? HT + 1 : HT, l < 2);
   endtask

   initial begin : stimulus
      repeat (3) @(negedge clk);
      chk("reset_locked", int'(locked), 0);
      chk("reset_linestart", int'(ls), 0);
      chk("reset_htotal", int'(ht), 0);
      rst = 1'b0;

      repeat (5) frame(-1);
      chk("lock_boundary", lock_fs, 4);
      chk("lock_with_framestart", lock_with_fs, 1);
      chk("locked_after_5", int'(locked), 1);
      chk("h_total", int'(ht), 40);
      chk("v_total", int'(vt), 14);
      chk("no_err_clean", err_cnt, 0);

      frame(5);
      chk("active_count", prev_act, 160);
      chk("first_x", pfx, 0);
      chk("first_y", pfy, 0);
      chk("last_x", plx, 19);
      chk("last_y", ply, 7);
      chk("stretch_err_count", err_cnt, 1);
      chk("stretch_err_frame", err_fs, 6);
      chk("stretch_unlocked", int'(locked), 0);

      repeat (4) frame(-1);
      chk("relock_boundary", lock_fs, 10);
      chk("relocked", int'(locked), 1);

      repeat (2100) drive(1'b1, 1'b1);
      chk("timeout_err_count", err_cnt, 2);
      chk("timeout_unlocked", int'(locked), 0);

      repeat (5) frame(-1);
      chk("relock_after_timeout", lock_fs, 15);
      chk("relocked_after_timeout", int'(locked), 1);

      fork
         frame(-1);
         begin
            repeat (150) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            chk("midreset_locked", int'(locked), 0);
            chk("midreset_linestart", int'(ls), 0);
            chk("midreset_htotal", int'(ht), 0);
            rst = 1'b0;
         end
      join

      frame(-1);
      chk("framestart_has_linestart", fs_no_ls, 0);
      chk("unlocked_after_reset", int'(locked), 0);
      chk("err_total", err_cnt, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
